// File: rtl/vga_text_seg_render_pkg.sv
// Shared definitions for the VGA text segment renderer.
//   - Glyph cell geometry (32 x 48 cell, 4-pixel stroke) and the blank letter code.
//   - SEG_0..SEG_16 name the 17 segment bits of the hit mask and of seg_colors.
//   - in_range(): inclusive range test used by the glyph geometry.
package vga_text_seg_render_pkg;

  localparam logic [5:0] CELL_W     = 6'd32;
  localparam logic [5:0] CELL_H     = 6'd48;
  localparam logic [5:0] STROKE     = 6'd4;
  localparam logic [4:0] BLANK_CODE = 5'd31;
  localparam int         NSEG       = 17;

  typedef enum logic [4:0] {
    SEG_0,  SEG_1,  SEG_2,  SEG_3,  SEG_4,  SEG_5,  SEG_6,  SEG_7,  SEG_8,
    SEG_9,  SEG_10, SEG_11, SEG_12, SEG_13, SEG_14, SEG_15, SEG_16
  } seg_idx_t;

  function automatic logic in_range(input logic [5:0] v, input logic [5:0] lo,
                                    input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_seg_hit.sv
// Combinational 17-segment glyph geometry.
// Maps a pixel's position inside a character cell to the set of segments it
// lies on.
//   lx  in  6   column inside the cell (0..31 meaningful)
//   ly  in  6   row inside the cell (0..47)
//   hit out 17  bit k set when the pixel lies on segment k
module vga_seg_hit
  import vga_text_seg_render_pkg::*;
(
  input  logic [5:0]  lx,
  input  logic [5:0]  ly,
  output logic [16:0] hit
);

  logic       left_col, right_col, centre_col;
  logic       band_top, band_mid, band_bot;
  logic       upper, lower, mid_bar;
  logic       left_diag, right_diag;
  logic [5:0] u_l, u_r, w_u, w_l;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    hit        = '0;
    left_col   = lx < STROKE;
    right_col  = lx >= (CELL_W - STROKE);
    centre_col = in_range(lx, 6'd14, 6'd17);
    band_top   = ly < 6'd16;
    band_mid   = in_range(ly, 6'd16, 6'd31);
    band_bot   = ly >= 6'd32;
    upper      = in_range(ly, 6'd4, 6'd21);
    lower      = in_range(ly, 6'd26, 6'd43);
    mid_bar    = in_range(ly, 6'd22, 6'd25);
    left_diag  = in_range(lx, 6'd4, 6'd13);
    right_diag = in_range(lx, 6'd18, 6'd27);
    // Diagonal coordinates; they wrap outside their window but are only used
    // when the matching window flags are set.
    u_l = lx - 6'd4;
    u_r = lx - 6'd18;
    w_u = ly - 6'd4;
    w_l = ly - 6'd26;

    hit[SEG_0]  = ly < STROKE;
    hit[SEG_3]  = ly >= (CELL_H - STROKE);
    hit[SEG_5]  = left_col && band_top;
    hit[SEG_8]  = left_col && band_mid;
    hit[SEG_4]  = left_col && band_bot;
    hit[SEG_1]  = right_col && band_top;
    hit[SEG_9]  = right_col && band_mid;
    hit[SEG_2]  = right_col && band_bot;
    hit[SEG_6]  = mid_bar && in_range(lx, 6'd4, 6'd11);
    hit[SEG_16] = mid_bar && in_range(lx, 6'd12, 6'd19);
    hit[SEG_7]  = mid_bar && in_range(lx, 6'd20, 6'd27);
    hit[SEG_14] = centre_col && upper;
    hit[SEG_15] = centre_col && lower;
    // Diagonals are 2 rows tall per column step: w>>1 tracks u (or 9-u).
    hit[SEG_10] = left_diag  && upper && ((w_u >> 1) == u_l);
    hit[SEG_11] = right_diag && upper && ((w_u >> 1) == (6'd9 - u_r));
    hit[SEG_12] = left_diag  && lower && ((w_l >> 1) == (6'd9 - u_l));
    hit[SEG_13] = right_diag && lower && ((w_l >> 1) == u_r);
  end

endmodule

// File: rtl/vga_text_seg_render.sv
// VGA text row renderer: 8-slot letter string drawn as 17-segment glyphs.
// Stage S1 registers the slot/cell decode and segment hit mask, presents the
// slot's letter code to the segment-colour stage, and S2 picks the final
// colour from the returned segment colours. Latency 2 clocks, 1 pixel/clock.
// Writes go to a shadow string copied to the live string once per frame.
// Optional feature macro: VGA_TEXT_CURSOR_EN (blinking underline cursor).
//   clk, rst            pixel clock, asynchronous active-high reset
//   h_cnt, v_cnt, valid pixel position and active-video flag
//   hsync_in, vsync_in  raw syncs; hsync/vsync are these delayed 2 clocks
//   bg_color            theme background colour
//   wr_en/addr/letter   write one shadow slot; clear blanks all shadow slots
//   letter, seg_colors  letter code out, 17 x 12-bit segment colours back
//   vga_rgb             final pixel colour
//   commit              one-cycle pulse when shadow is copied to live
//   cursor_pos, cursor_on (VGA_TEXT_CURSOR_EN only) cursor slot and enable
module vga_text_seg_render
  import vga_text_seg_render_pkg::*;
#(
  parameter int X0       = 64,
  parameter int Y0       = 64,
  parameter int NCHAR    = 8,
  parameter int PITCH    = 40,
  parameter int V_ACTIVE = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   h_cnt,
  input  logic [9:0]   v_cnt,
  input  logic         valid,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic [11:0]  bg_color,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [4:0]   wr_letter,
  input  logic         clear,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic [2:0]   cursor_pos,
  input  logic         cursor_on,
`endif
  output logic [4:0]   letter,
  input  logic [203:0] seg_colors,
  output logic [11:0]  vga_rgb,
  output logic         hsync,
  output logic         vsync,
  output logic         commit
);

  localparam logic [9:0] X_LO     = 10'(X0);
  localparam logic [9:0] X_HI     = 10'(X0 + NCHAR * PITCH);
  localparam logic [9:0] Y_LO     = 10'(Y0);
  localparam logic [9:0] Y_HI     = Y_LO + 10'(CELL_H);
  localparam logic [9:0] V_COMMIT = 10'(V_ACTIVE);
  localparam logic [9:0] PITCH_W  = 10'(PITCH);

  logic [4:0] shadow [NCHAR];
  logic [4:0] live   [NCHAR];
  logic       commit_now;

  assign commit_now = (h_cnt == 10'd0) && (v_cnt == V_COMMIT);

  // ---------------- letter string ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: shadow/live are small flop arrays and must come out of reset as
      // blank text, so they are reset like any other register.
      for (int i = 0; i < NCHAR; i++) begin
        shadow[i] <= BLANK_CODE;
        live[i]   <= BLANK_CODE;
      end
      commit <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so live copies
      // the pre-edge shadow even when a write lands in the commit cycle.
      if (clear) begin
        for (int i = 0; i < NCHAR; i++) shadow[i] <= BLANK_CODE;
      end else if (wr_en && (32'(wr_addr) < NCHAR)) begin
        shadow[wr_addr] <= wr_letter;
      end
      if (commit_now) begin
        for (int i = 0; i < NCHAR; i++) live[i] <= shadow[i];
      end
      commit <= commit_now;
    end
  end

`ifdef VGA_TEXT_CURSOR_EN
  logic [4:0] frame_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= '0;
    else if (commit_now) frame_cnt <= frame_cnt + 5'd1;
  end
`endif

  // ---------------- S1: cell decode ----------------
  logic [9:0]  rel_x;
  logic [2:0]  slot_d;
  logic [5:0]  lx_d, ly_d;
  logic        in_text_d, in_cell_d;
  logic [16:0] hit_d;

  always_comb begin
    rel_x     = h_cnt - X_LO;
    slot_d    = 3'(rel_x / PITCH_W);
    lx_d      = 6'(rel_x % PITCH_W);
    ly_d      = 6'(v_cnt - Y_LO);
    in_text_d = valid && (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                (v_cnt >= Y_LO) && (v_cnt < Y_HI);
    in_cell_d = in_text_d && (lx_d < CELL_W);
  end

  vga_seg_hit u_seg_hit (
    .lx  (lx_d),
    .ly  (ly_d),
    .hit (hit_d)
  );

  logic        s1_valid, s1_in_cell, s1_hs, s1_vs;
  logic [2:0]  s1_slot;
  logic [16:0] s1_hit;
  logic [11:0] s1_bg;
`ifdef VGA_TEXT_CURSOR_EN
  logic [5:0]  s1_ly;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_in_cell <= 1'b0;
      s1_slot    <= '0;
      s1_hit     <= '0;
      s1_bg      <= '0;
      // Syncs idle high, so the blanked pipeline carries inactive syncs.
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
`ifdef VGA_TEXT_CURSOR_EN
      s1_ly      <= '0;
`endif
    end else begin
      s1_valid   <= valid;
      s1_in_cell <= in_cell_d;
      s1_slot    <= slot_d;
      s1_hit     <= hit_d;
      s1_bg      <= bg_color;
      s1_hs      <= hsync_in;
      s1_vs      <= vsync_in;
`ifdef VGA_TEXT_CURSOR_EN
      s1_ly      <= ly_d;
`endif
    end
  end

  assign letter = s1_in_cell ? live[s1_slot] : BLANK_CODE;

  // ---------------- S2: colour select ----------------
  logic [11:0] seg_rgb, rgb_d;
  logic        found;

  always_comb begin
    seg_rgb = s1_bg;
    found   = 1'b0;
    // Lowest lit segment whose colour differs from the background wins.
    for (int k = 0; k < NSEG; k++) begin
      if (!found && s1_hit[k] && (seg_colors[12*k +: 12] != s1_bg)) begin
        seg_rgb = seg_colors[12*k +: 12];
        found   = 1'b1;
      end
    end
    if (!s1_valid)        rgb_d = 12'h000;
    else if (!s1_in_cell) rgb_d = s1_bg;
    else                  rgb_d = seg_rgb;
`ifdef VGA_TEXT_CURSOR_EN
    // Underline on the cell's last two rows, blinking with frame_cnt[4].
    if (s1_in_cell && cursor_on && !frame_cnt[4] &&
        (s1_slot == cursor_pos) && (s1_ly >= 6'd46)) begin
      rgb_d = ~s1_bg;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_rgb <= 12'h000;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      vga_rgb <= rgb_d;
      hsync   <= s1_hs;
      vsync   <= s1_vs;
    end
  end

endmodule

// File: tb/tb_vga_text_seg_render.sv
// Scoreboard bench for vga_text_seg_render. The driver pushes the expected
// response of each issued pixel with the cycle it is due; a negedge monitor
// pops and compares. The bench also plays the segment-colour stage.
module tb_vga_text_seg_render;

  localparam int KIND_RGB = 0, KIND_LET = 1, KIND_COMMIT = 2, KIND_HS = 3, KIND_VS = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [11:0] exp;
    string       name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   h_cnt, v_cnt;
  logic         valid, hsync_in, vsync_in;
  logic [11:0]  bg_color;
  logic         wr_en, clear;
  logic [2:0]   wr_addr;
  logic [4:0]   wr_letter;
  logic [4:0]   letter;
  logic [203:0] seg_colors;
  logic [11:0]  vga_rgb;
  logic         hsync, vsync, commit;

  logic [11:0]  fg_tbl [17];
  logic [16:0]  glyph_mask;
  exp_t         exp_q [$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  vga_text_seg_render dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .bg_color   (bg_color),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_letter  (wr_letter),
    .clear      (clear),
`ifdef VGA_TEXT_CURSOR_EN
    .cursor_pos (3'd0),
    .cursor_on  (1'b0),
`endif
    .letter     (letter),
    .seg_colors (seg_colors),
    .vga_rgb    (vga_rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .commit     (commit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Segment-colour stage model: letter 0 = 'A', 2 = 'C', 3 = every segment.
  always_comb begin
    seg_colors = '0;
    case (letter)
      5'd0:    glyph_mask = 17'h103F7;
      5'd2:    glyph_mask = 17'h00139;
      5'd3:    glyph_mask = 17'h1FFFF;
      default: glyph_mask = 17'h00000;
    endcase
    for (int k = 0; k < 17; k++)
      seg_colors[12*k +: 12] = glyph_mask[k] ? fg_tbl[k] : bg_color;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int lat, input logic [11:0] exp, input string name);
    exp_t e;
    e.due = cyc + lat; e.kind = kind; e.exp = exp; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every entry whose due cycle has arrived.
  always @(negedge clk) begin
    int i;
    exp_t e;
    logic [11:0] act;
    if (!rst) begin
      i = 0;
      while (i < exp_q.size()) begin
        if (exp_q[i].due <= cyc) begin
          e = exp_q[i];
          exp_q.delete(i);
          case (e.kind)
            KIND_RGB:    act = vga_rgb;
            KIND_LET:    act = {7'b0, letter};
            KIND_COMMIT: act = {11'b0, commit};
            KIND_HS:     act = {11'b0, hsync};
            default:     act = {11'b0, vsync};
          endcase
          if (e.due < cyc) check({e.name, "_late"}, 12'(cyc), 12'(e.due));
          else             check(e.name, act, e.exp);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic pix(input int h, input int v, input logic vld, input logic [11:0] exp_rgb,
                     input int exp_let, input string name,
                     input logic hs = 1'b1, input logic vs = 1'b1);
    @(posedge clk); #1;
    h_cnt = 10'(h); v_cnt = 10'(v); valid = vld; hsync_in = hs; vsync_in = vs;
    if (exp_let >= 0) push(KIND_LET, 1, 12'(exp_let), {name, "_letter"});
    push(KIND_RGB, 2, exp_rgb, name);
    push(KIND_HS, 2, {11'b0, hs}, {name, "_hsync"});
    push(KIND_VS, 2, {11'b0, vs}, {name, "_vsync"});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      h_cnt = 10'd700; v_cnt = 10'd500; valid = 1'b0; wr_en = 1'b0; clear = 1'b0;
    end
  endtask

  task automatic wr(input int addr, input int code, input logic clr);
    @(posedge clk); #1;
    h_cnt = 10'd700; v_cnt = 10'd500; valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'(addr); wr_letter = 5'(code); clear = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; clear = 1'b0;
  endtask

  task automatic do_commit();
    pix(0, 480, 1'b0, 12'h000, -1, "commit_row");
    push(KIND_COMMIT, 1, 12'h001, "commit_pulse");
    pix(700, 500, 1'b0, 12'h000, -1, "after_commit");
    push(KIND_COMMIT, 1, 12'h000, "commit_single");
  endtask

  int          geo_lx  [18] = '{1, 29, 30, 10, 2, 2, 8, 24, 2, 29, 6, 27, 5, 20, 15, 15, 15, 7};
  int          geo_ly  [18] = '{1, 5, 40, 46, 40, 10, 24, 24, 20, 20, 8, 4, 43, 30, 10, 30, 23, 8};
  logic [11:0] geo_exp [18] = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304, 12'h305,
                                12'h306, 12'h307, 12'h308, 12'h309, 12'h30a, 12'h30b,
                                12'h30c, 12'h30d, 12'h30e, 12'h30f, 12'h310, 12'h124};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; h_cnt = 10'd700; v_cnt = 10'd500; valid = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; bg_color = 12'h000;
    wr_en = 1'b0; wr_addr = '0; wr_letter = '0; clear = 1'b0;
    for (int k = 0; k < 17; k++) fg_tbl[k] = 12'hfff;

    repeat (3) @(posedge clk); #1;
    check("reset_rgb", vga_rgb, 12'h000);
    check("reset_hsync", {11'b0, hsync}, 12'h001);
    check("reset_vsync", {11'b0, vsync}, 12'h001);
    check("reset_letter", {7'b0, letter}, 12'h01f);
    check("reset_commit", {11'b0, commit}, 12'h000);
    rst = 1'b0;

    pix(74, 65, 1'b1, 12'h000, 31, "blank_slot0");
    wr(0, 0, 1'b0);
    pix(74, 65, 1'b1, 12'h000, 31, "precommit_slot0");
    do_commit();
    pix(74, 65, 1'b1, 12'hfff, 0, "A_seg0");
    pix(80, 65, 1'b1, 12'hfff, 0, "A_seg0_mid");
    pix(96, 74, 1'b1, 12'h000, 31, "slot_gap");

    wr(1, 2, 1'b0);
    do_commit();
    pix(134, 74, 1'b1, 12'h000, 2, "C_seg1_off");
    pix(105, 74, 1'b1, 12'hfff, 2, "C_seg5_on");

    idle(2); bg_color = 12'h124;
    pix(96, 74, 1'b1, 12'h124, 31, "gap_bg");
    pix(74, 65, 1'b0, 12'h000, -1, "invalid_black");
    pix(63, 65, 1'b1, 12'h124, 31, "left_edge_out");
    pix(64, 65, 1'b1, 12'hfff, 0, "left_edge_in");
    pix(383, 65, 1'b1, 12'h124, 31, "last_gap");
    pix(384, 65, 1'b1, 12'h124, 31, "right_edge_out");
    pix(74, 111, 1'b1, 12'h124, 0, "bottom_row_in");
    pix(74, 112, 1'b1, 12'h124, 31, "below_row");

    idle(2); fg_tbl[0] = 12'h111; fg_tbl[5] = 12'h0a5;
    pix(65, 65, 1'b1, 12'h111, 0, "prio_lowest");
    idle(2); fg_tbl[0] = 12'h124;
    pix(65, 65, 1'b1, 12'h0a5, 0, "prio_skip_bg");
    idle(2);

    wr(2, 3, 1'b0);
    do_commit();
    for (int k = 0; k < 17; k++) fg_tbl[k] = 12'h300 + 12'(k);
    for (int i = 0; i < 18; i++)
      pix(144 + geo_lx[i], 64 + geo_ly[i], 1'b1, geo_exp[i], 3,
          $sformatf("geo_%0d_%0d", geo_lx[i], geo_ly[i]));

    idle(2);
    wr(4, 0, 1'b1);
    do_commit();
    pix(74, 65, 1'b1, 12'h124, 31, "clear_slot0");
    pix(105, 74, 1'b1, 12'h124, 31, "clear_slot1");
    pix(150, 72, 1'b1, 12'h124, 31, "clear_slot2");

    // Write in the commit cycle reaches shadow only.
    @(posedge clk); #1;
    h_cnt = 10'd0; v_cnt = 10'd480; valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_letter = 5'd0;
    push(KIND_COMMIT, 1, 12'h001, "commit_with_write");
    @(posedge clk); #1;
    wr_en = 1'b0; h_cnt = 10'd700; v_cnt = 10'd500;
    pix(74, 65, 1'b1, 12'h124, 31, "write_in_commit_hidden");
    do_commit();
    pix(74, 65, 1'b1, 12'h300, 0, "write_in_commit_shown");

    pix(74, 65, 1'b1, 12'h300, 0, "sync_a", 1'b1, 1'b0);
    pix(74, 65, 1'b1, 12'h300, 0, "sync_b", 1'b0, 1'b1);
    pix(74, 65, 1'b1, 12'h300, 0, "sync_c", 1'b0, 1'b1);
    pix(74, 65, 1'b1, 12'h300, 0, "sync_d", 1'b1, 1'b0);
    pix(74, 65, 1'b1, 12'h300, 0, "pre_rst_a", 1'b0, 1'b0);
    pix(74, 65, 1'b1, 12'h300, 0, "pre_rst_b", 1'b0, 1'b0);
    pix(74, 65, 1'b1, 12'h300, 0, "pre_rst_c", 1'b0, 1'b0);

    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midline_rst_rgb", vga_rgb, 12'h000);
    check("midline_rst_hsync", {11'b0, hsync}, 12'h001);
    check("midline_rst_vsync", {11'b0, vsync}, 12'h001);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    pix(74, 65, 1'b1, 12'h124, 31, "post_rst_blank");
    idle(4);
    check("queue_drained", 12'(exp_q.size()), 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
